// File: rtl/bsg_gateway_clk_div_bank_if.sv
// Configuration write port of the divider bank: channel select, enable, divide, phase and ready.
interface bsg_gateway_clk_div_bank_if #(
    parameter int unsigned channels_p  = 4,
    parameter int unsigned div_width_p = 8
);
    localparam int unsigned ch_width_lp = (channels_p > 1) ? $clog2(channels_p) : 1;

    logic                   cfg_v_i;
    logic [ch_width_lp-1:0] cfg_ch_i;
    logic                   cfg_en_i;
    logic [div_width_p-1:0] cfg_div_i;
    logic [div_width_p-1:0] cfg_phase_i;
    logic                   cfg_ready_o;

    modport master (
        output cfg_v_i, cfg_ch_i, cfg_en_i, cfg_div_i, cfg_phase_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_v_i, cfg_ch_i, cfg_en_i, cfg_div_i, cfg_phase_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/bsg_gateway_clk_div_bank.sv
// Bank of runtime-programmable 50%-duty clock dividers, qualified by a debounced PLL lock.
// Reconfiguration of a running channel is deferred to its falling toggle so no high phase is cut short.
module bsg_gateway_clk_div_bank #(
    parameter int unsigned channels_p   = 4,
    parameter int unsigned div_width_p  = 8,
    parameter int unsigned lock_delay_p = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          pll_locked_i,
    bsg_gateway_clk_div_bank_if.slave     cfg,
    output logic [channels_p-1:0]         clk_o,
    output logic [channels_p-1:0]         tick_o,
    output logic                          locked_o
);
    localparam int unsigned ch_width_lp   = (channels_p > 1) ? $clog2(channels_p) : 1;
    localparam int unsigned lock_width_lp = $clog2(lock_delay_p + 1);

    logic                     r_lock_s1, r_lock_s2, r_locked, w_locked_n;
    logic [lock_width_lp-1:0] r_lock_cnt, w_lock_cnt_n;
    logic                     w_lock_lost;

    logic [channels_p-1:0]    r_run, r_clk, r_tick, r_pend_v, r_pend_en;
    logic [channels_p-1:0]    w_run_n, w_clk_n, w_tick_n, w_pend_v_n, w_pend_en_n;
    logic [div_width_p-1:0]   r_cnt [channels_p];
    logic [div_width_p-1:0]   r_div [channels_p];
    logic [div_width_p-1:0]   r_pend_div [channels_p];
    logic [div_width_p-1:0]   r_pend_phase [channels_p];
    logic [div_width_p-1:0]   w_cnt_n [channels_p];
    logic [div_width_p-1:0]   w_div_n [channels_p];
    logic [div_width_p-1:0]   w_pend_div_n [channels_p];
    logic [div_width_p-1:0]   w_pend_phase_n [channels_p];

    logic [channels_p-1:0]    w_hit;
    logic                     w_ready, w_wr;

    function automatic logic [div_width_p-1:0] min_div(input logic [div_width_p-1:0] a,
                                                       input logic [div_width_p-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Lock is lost as soon as either synchronizer stage sees low.
    assign w_lock_lost = ~(r_lock_s1 & r_lock_s2);

    always_comb begin
        w_lock_cnt_n = r_lock_cnt;
        w_locked_n   = r_locked;
        if (w_lock_lost) begin
            w_lock_cnt_n = '0;
            w_locked_n   = 1'b0;
        end else if (!r_locked) begin
            w_lock_cnt_n = r_lock_cnt + lock_width_lp'(1);
            if (w_lock_cnt_n == lock_width_lp'(lock_delay_p))
                w_locked_n = 1'b1;
        end
    end

    // One-hot channel decode; an out-of-range select matches nothing and is silently dropped.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < channels_p; i++)
            w_hit[i] = (cfg.cfg_ch_i == ch_width_lp'(i));
    end

    assign w_ready         = r_locked & ~(|(w_hit & r_pend_v));
    assign cfg.cfg_ready_o = w_ready;
    assign w_wr            = cfg.cfg_v_i & w_ready;

    always_comb begin
        w_run_n        = r_run;
        w_clk_n        = r_clk;
        w_tick_n       = '0;
        w_pend_v_n     = r_pend_v;
        w_pend_en_n    = r_pend_en;
        w_cnt_n        = r_cnt;
        w_div_n        = r_div;
        w_pend_div_n   = r_pend_div;
        w_pend_phase_n = r_pend_phase;
        for (int i = 0; i < channels_p; i++) begin
            if (w_lock_lost) begin
                w_run_n[i]    = 1'b0;
                w_pend_v_n[i] = 1'b0;
                w_clk_n[i]    = 1'b0;
                w_cnt_n[i]    = '0;
            end else if (r_run[i]) begin
                if (r_cnt[i] == r_div[i]) begin
                    w_cnt_n[i]  = '0;
                    w_clk_n[i]  = ~r_clk[i];
                    w_tick_n[i] = ~r_clk[i];
                    // Pending writes only take effect on the falling toggle.
                    if (r_clk[i] && r_pend_v[i]) begin
                        w_pend_v_n[i] = 1'b0;
                        if (r_pend_en[i]) begin
                            w_div_n[i] = r_pend_div[i];
                            w_cnt_n[i] = min_div(r_pend_phase[i], r_pend_div[i]);
                        end else begin
                            w_run_n[i] = 1'b0;
                        end
                    end
                end else begin
                    w_cnt_n[i] = r_cnt[i] + div_width_p'(1);
                end
                if (w_wr && w_hit[i]) begin
                    w_pend_v_n[i]     = 1'b1;
                    w_pend_en_n[i]    = cfg.cfg_en_i;
                    w_pend_div_n[i]   = cfg.cfg_div_i;
                    w_pend_phase_n[i] = cfg.cfg_phase_i;
                end
            end else if (w_wr && w_hit[i]) begin
                w_div_n[i] = cfg.cfg_div_i;
                if (cfg.cfg_en_i) begin
                    w_run_n[i] = 1'b1;
                    w_clk_n[i] = 1'b0;
                    w_cnt_n[i] = min_div(cfg.cfg_phase_i, cfg.cfg_div_i);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_lock_s1  <= 1'b0;
            r_lock_s2  <= 1'b0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
            r_run      <= '0;
            r_clk      <= '0;
            r_tick     <= '0;
            r_pend_v   <= '0;
            r_pend_en  <= '0;
            for (int i = 0; i < channels_p; i++) begin
                r_cnt[i]        <= '0;
                r_div[i]        <= '0;
                r_pend_div[i]   <= '0;
                r_pend_phase[i] <= '0;
            end
        end else begin
            r_lock_s1    <= pll_locked_i;
            r_lock_s2    <= r_lock_s1;
            r_lock_cnt   <= w_lock_cnt_n;
            r_locked     <= w_locked_n;
            r_run        <= w_run_n;
            r_clk        <= w_clk_n;
            r_tick       <= w_tick_n;
            r_pend_v     <= w_pend_v_n;
            r_pend_en    <= w_pend_en_n;
            r_cnt        <= w_cnt_n;
            r_div        <= w_div_n;
            r_pend_div   <= w_pend_div_n;
            r_pend_phase <= w_pend_phase_n;
        end
    end

    assign clk_o    = r_clk;
    assign tick_o   = r_tick;
    assign locked_o = r_locked;
endmodule
